// File: rtl/window_framer.sv
// window_framer: snapshots a 16-sample window every HOP strobes and streams it Hann-weighted, oldest first.
// Define WINDOW_EN for Hann weighting; otherwise samples pass through with unity weight.
module window_framer #(
    parameter int HOP   = 16,
    parameter int SAT_W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         new_t,
    input  logic [383:0] t_in,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic [23:0]  frame_data,
    output logic [3:0]   frame_idx,
    output logic         frame_last,
    output logic         busy,
    output logic [7:0]   overrun_cnt
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic signed [39:0] HI = (40'sd1 <<< (SAT_W - 1)) - 40'sd1;
    localparam logic signed [39:0] LO = -(40'sd1 <<< (SAT_W - 1));

    state_t             state, state_nx;
    logic [3:0]         hop_cnt;
    logic [23:0]        snap [16];
    logic               hop, accept, fin;
    logic               take, drop, bypass, load, over;
    logic [3:0]         sel, ix;
    logic signed [23:0] sample;
    logic signed [39:0] r;
    logic [23:0]        sat;

    assign hop    = new_t && hop_cnt == 4'(HOP - 1);
    assign accept = frame_valid && frame_ready;
    assign fin    = accept && frame_last;
    assign busy   = frame_valid;

    always_comb begin
        take     = 1'b0;
        drop     = 1'b0;
        bypass   = 1'b0;
        load     = 1'b0;
        over     = 1'b0;
        state_nx = state;
        if (state == IDLE) begin
            take     = hop;
            state_nx = hop ? STREAM : IDLE;
        end else begin
            // a hop landing on the final accept restarts straight from the live bus
            take     = hop && fin;
            bypass   = hop && fin;
            drop     = fin && !hop;
            over     = hop && !fin;
            load     = !frame_valid || (accept && !drop);
            state_nx = drop ? IDLE : STREAM;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    assign sel    = frame_valid ? frame_idx + 4'd1 : 4'd0;
    assign ix     = bypass ? 4'd0 : sel;
    assign sample = bypass ? t_in[383:360] : snap[ix];

`ifdef WINDOW_EN
    localparam logic [15:0] W [16] = '{16'd0, 16'd1247, 16'd4799, 16'd10114, 16'd16384, 16'd22654,
        16'd27969, 16'd31521, 16'd32767, 16'd31521, 16'd27969, 16'd22654, 16'd16384, 16'd10114,
        16'd4799, 16'd1247};
    logic signed [39:0] p;
    assign p = 40'(sample) * 40'($signed({1'b0, W[ix]}));
    assign r = (p + 40'sd16384) >>> 15;
`else
    assign r = 40'(sample);
`endif

    assign sat = r > HI ? HI[23:0] : r < LO ? LO[23:0] : r[23:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hop_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_idx   <= '0;
            frame_last  <= 1'b0;
            overrun_cnt <= '0;
            for (int i = 0; i < 16; i++) snap[i] <= '0;
        end else begin
            if (new_t) hop_cnt <= hop ? 4'd0 : hop_cnt + 4'd1;
            if (take)
                for (int i = 0; i < 16; i++) snap[i] <= t_in[(15 - i)*24 +: 24];
            if (load) begin
                frame_valid <= 1'b1;
                frame_data  <= sat;
                frame_idx   <= ix;
                frame_last  <= ix == 4'd15;
            end else if (drop) begin
                frame_valid <= 1'b0;
                frame_last  <= 1'b0;
            end
            if (over && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_window_framer.sv
// tb_window_framer: directed frames on HOP=16 and HOP=1 instances with queue scoreboards.
module tb_window_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         new_t, frame_ready, frame_valid, frame_last, busy;
    logic [383:0] t_in;
    logic [23:0]  frame_data;
    logic [3:0]   frame_idx;
    logic [7:0]   overrun_cnt;

    logic         b_new_t, b_ready, b_valid, b_last, b_busy;
    logic [383:0] b_t_in;
    logic [23:0]  b_data;
    logic [3:0]   b_idx;
    logic [7:0]   b_overrun;

    int checks = 0;
    int errors = 0;
    logic [28:0] q[$];
    logic [28:0] bq[$];

`ifdef WINDOW_EN
    localparam int K1 [16] = '{0, 39, 150, 316, 512, 708, 874, 985, 1024, 985, 874, 708, 512, 316, 150, 39};
    localparam int MID = 131067;
`else
    localparam int K1 [16] = '{default: 1024};
    localparam int MID = 131071;
`endif
    int sat_exp [16];

    window_framer #(.HOP(16), .SAT_W(18)) u16 (
        .clk(clk), .reset(reset), .new_t(new_t), .t_in(t_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .frame_idx(frame_idx), .frame_last(frame_last), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    window_framer #(.HOP(1), .SAT_W(18)) u1 (
        .clk(clk), .reset(reset), .new_t(b_new_t), .t_in(b_t_in),
        .frame_valid(b_valid), .frame_ready(b_ready), .frame_data(b_data),
        .frame_idx(b_idx), .frame_last(b_last), .busy(b_busy), .overrun_cnt(b_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push16(input int d [16], input bit b);
        for (int i = 0; i < 16; i++) begin
            if (b) bq.push_back({1'(i == 15), 4'(i), 24'(d[i])});
            else   q.push_back({1'(i == 15), 4'(i), 24'(d[i])});
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            new_t = 1'b1;
            @(posedge clk); #1;
            new_t = 1'b0;
        end
    endtask

    task automatic wait_drain(input bit b);
        int n = 0;
        while (n < 400 && !(b ? (bq.size() == 0 && !b_valid) : (q.size() == 0 && !frame_valid))) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout inst %0d left %0d required 0", b, b ? bq.size() : q.size());
        end
    endtask

    task automatic wait_idx(input int k, input bit b);
        int n = 0;
        while (n < 100 && !(b ? (b_valid && b_idx == 4'(k)) : (frame_valid && frame_idx == 4'(k)))) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) begin
            checks++; errors++;
            $display("FAIL idx_timeout inst %0d required idx %0d", b, k);
        end
    endtask

    always @(negedge clk)
        if (reset && frame_valid && frame_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL u16_beat unexpected idx %0d data %0h required none", frame_idx, frame_data);
            end else check("u16_beat", {3'b0, frame_last, frame_idx, frame_data}, {3'b0, q.pop_front()});
        end

    always @(negedge clk)
        if (reset && b_valid && b_ready) begin
            if (bq.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1_beat unexpected idx %0d data %0h required none", b_idx, b_data);
            end else check("u1_beat", {3'b0, b_last, b_idx, b_data}, {3'b0, bq.pop_front()});
        end

    initial begin
        reset = 1'b0; new_t = 1'b0; frame_ready = 1'b1; t_in = '0;
        b_new_t = 1'b0; b_ready = 1'b1; b_t_in = '0;
        #12;
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_data", 32'(frame_data), 0);
        check("rst_idx", 32'(frame_idx), 0);
        check("rst_last", 32'(frame_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // first frame: 1024 everywhere, latency and busy
        t_in = {16{24'd1024}};
        pulses(15);
        check("no_frame_before_hop", 32'(frame_valid), 0);
        push16(K1, 0);
        pulses(1);
        check("latency_edge_k", 32'(frame_valid), 0);
        @(posedge clk); #1;
        check("latency_valid", 32'(frame_valid), 1);
        check("latency_idx", 32'(frame_idx), 0);
        check("busy_high", 32'(busy), 1);
        wait_drain(0);
        check("busy_low", 32'(busy), 0);

        // saturation boundaries at idx 8..10
        sat_exp = '{default: 0};
        sat_exp[8] = MID; sat_exp[9] = 131071; sat_exp[10] = 24'hFE0000;
        t_in = '0;
        t_in[7*24 +: 24] = 24'h01FFFF;
        t_in[6*24 +: 24] = 24'h7FFFFF;
        t_in[5*24 +: 24] = 24'h800000;
        push16(sat_exp, 0);
        pulses(16);
        wait_drain(0);

        // 40-cycle stall at idx 5
        t_in = {16{24'd1024}};
        push16(K1, 0);
        pulses(16);
        wait_idx(5, 0);
        frame_ready = 1'b0;
        repeat (4) begin
            repeat (10) @(posedge clk);
            #1;
            check("stall_valid", 32'(frame_valid), 1);
            check("stall_idx", 32'(frame_idx), 5);
            check("stall_data", 32'(frame_data), 32'(24'(K1[5])));
        end
        frame_ready = 1'b1;
        wait_drain(0);

        // one overrun, frame intact
        push16(K1, 0);
        pulses(16);
        frame_ready = 1'b0;
        t_in = {16{24'h000007}};
        pulses(16);
        check("overrun_one", 32'(overrun_cnt), 1);
        check("overrun_hold_idx", 32'(frame_idx), 0);
        check("overrun_hold_valid", 32'(frame_valid), 1);
        frame_ready = 1'b1;
        wait_drain(0);

        // 300 more drops saturate the counter
        t_in = {16{24'd1024}};
        push16(K1, 0);
        pulses(16);
        frame_ready = 1'b0;
        pulses(300 * 16);
        check("overrun_sat", 32'(overrun_cnt), 255);
        frame_ready = 1'b1;
        wait_drain(0);

        // HOP=1: hop on last accept starts next frame with no bubble
        b_t_in = {16{24'd1024}};
        push16(K1, 1);
        b_new_t = 1'b1;
        @(posedge clk); #1;
        b_new_t = 1'b0;
        wait_idx(15, 1);
        push16(K1, 1);
        b_new_t = 1'b1;
        @(posedge clk); #1;
        b_new_t = 1'b0;
        check("b2b_valid", 32'(b_valid), 1);
        check("b2b_idx", 32'(b_idx), 0);
        check("b2b_overrun", 32'(b_overrun), 0);
        wait_drain(1);

        // asynchronous reset mid-frame
        push16(K1, 0);
        pulses(16);
        wait_idx(7, 0);
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(frame_valid), 0);
        check("arst_data", 32'(frame_data), 0);
        check("arst_idx", 32'(frame_idx), 0);
        check("arst_last", 32'(frame_last), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_overrun", 32'(overrun_cnt), 0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        pulses(15);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet", 32'(frame_valid), 0);
        push16(K1, 0);
        pulses(1);
        @(posedge clk); #1;
        check("post_rst_valid", 32'(frame_valid), 1);
        wait_drain(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
